// File: rtl/mult_share_arbiter.sv
// ============================================================================
//  Module      : mult_share_arbiter (with eightbitmultiplier)
//  Description : Round-robin sharing of one combinational 8x8 unsigned array
//                multiplier among NUM_REQ valid/ready requesters. Results are
//                registered into a single-entry, id-tagged output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Combinational 8x8 unsigned array multiplier built from shifted partial
// products summed row by row.
module eightbitmultiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] w_pp [8];
  logic [15:0] w_acc;

  // One partial-product row per multiplier bit: a shifted left by the row index
  for (genvar i = 0; i < 8; i++) begin : g_pp_row
    assign w_pp[i] = b[i] ? ({8'd0, a} << i) : 16'd0;
  end

  // Sum the partial-product rows; the 16-bit sum cannot overflow (255*255 = 65025)
  always_comb begin
    w_acc = 16'd0;
    for (int i = 0; i < 8; i++) begin
      w_acc = w_acc + w_pp[i];
    end
  end

  assign p = w_acc;

endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  output logic [15:0]          resp_p,
  output logic [ID_W-1:0]      resp_id,
  input  logic                 resp_ready,
  output logic [15:0]          ops_done
);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [ID_W-1:0] r_rr_ptr;
  logic            r_resp_valid;
  logic [15:0]     r_resp_p;
  logic [ID_W-1:0] r_resp_id;
  logic [15:0]     r_ops_done;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [7:0]         w_x_arr [NUM_REQ];
  logic [7:0]         w_y_arr [NUM_REQ];
  logic [ID_W-1:0]    w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_found;
  int                 w_sum;
  logic               w_can_accept;
  logic               w_drain;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_transfer;
  logic [ID_W-1:0]    w_next_ptr;
  logic [7:0]         w_mul_x;
  logic [7:0]         w_mul_y;
  logic [15:0]        w_product;

  // Split the flat operand buses into per-requester bytes
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_operand_split
    assign w_x_arr[i] = req_x[8*i +: 8];
    assign w_y_arr[i] = req_y[8*i +: 8];
  end

  // The buffer can take a new result when empty or when it drains this cycle
  assign w_can_accept = !r_resp_valid || resp_ready;
  assign w_drain      = r_resp_valid && resp_ready;

  // Round-robin search: first valid requester at or above r_rr_ptr, with wrap
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(r_rr_ptr) + k;
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end
      w_idx = ID_W'(w_sum);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // One-hot grant, gated by buffer space and held off entirely during reset.
  // It depends only on req_valid and buffer state, never on the operands.
  always_comb begin
    w_ready = '0;
    if (!rst && w_can_accept && w_found) begin
      w_ready = NUM_REQ'(1) << w_grant;
    end
  end

  assign req_ready  = w_ready;
  assign w_transfer = |(req_valid & w_ready);

  // Pointer advances to the requester just past the winner
  assign w_next_ptr = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant + 1'b1);

  // Steer the winner's operands into the single shared multiplier
  assign w_mul_x = w_x_arr[w_grant];
  assign w_mul_y = w_y_arr[w_grant];

  eightbitmultiplier u_mult (
    .a (w_mul_x),
    .b (w_mul_y),
    .p (w_product)
  );

  // Output buffer and round-robin pointer; a new transfer reloads the buffer
  // even while it drains, giving one result per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_p     <= 16'd0;
      r_resp_id    <= '0;
      r_rr_ptr     <= '0;
    end else if (w_transfer) begin
      r_resp_valid <= 1'b1;
      r_resp_p     <= w_product;
      r_resp_id    <= w_grant;
      r_rr_ptr     <= w_next_ptr;
    end else if (w_drain) begin
      r_resp_valid <= 1'b0;
    end
  end

  // Completed-response counter; wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops_done <= 16'd0;
    end else if (w_drain) begin
      r_ops_done <= r_ops_done + 16'd1;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_p     = r_resp_p;
  assign resp_id    = r_resp_id;
  assign ops_done   = r_ops_done;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
// ============================================================================
//  Module      : tb_mult_share_arbiter
//  Description : Self-checking bench for mult_share_arbiter (NUM_REQ = 4)
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [15:0] resp_p;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic [15:0] ops_done;

  int n_assert;
  int n_fail;

  // Reference model state: buffer contents, pointer, completed count
  bit m_valid;
  int m_p;
  int m_id;
  int m_ptr;
  int m_ops;
  int last_grant;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_p     (resp_p),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First valid requester scanning upward from ptr with wrap; -1 if none
  function automatic int pick(input int ptr, input logic [3:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int byte_of(input logic [31:0] bus, input int i);
    return int'((bus >> (8 * i)) & 32'hFF);
  endfunction

  // Drive one cycle of inputs, check the grant, clock it, update model, check outputs
  task automatic cycle(input logic r, input logic [3:0] v, input logic [31:0] xs,
                       input logic [31:0] ys, input logic rr);
    int g;
    logic [3:0] exp_ready;
    rst = r; req_valid = v; req_x = xs; req_y = ys; resp_ready = rr;
    #1;
    g = pick(m_ptr, v);
    exp_ready = 4'b0;
    if (!r && (!m_valid || rr) && g >= 0) exp_ready = 4'(1 << g);
    check("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_p = 0; m_id = 0; m_ptr = 0; m_ops = 0;
      last_grant = -1;
    end else begin
      if (m_valid && rr) m_ops = (m_ops + 1) % 65536;
      if (exp_ready != 0) begin
        m_p = byte_of(xs, g) * byte_of(ys, g);
        m_id = g;
        m_valid = 1;
        m_ptr = (g + 1) % NUM_REQ;
        last_grant = g;
      end else begin
        last_grant = -1;
        if (m_valid && rr) m_valid = 0;
      end
    end
    #1;
    check("resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
    check("resp_p",     {16'd0, resp_p},     32'(m_p));
    check("resp_id",    {30'd0, resp_id},    32'(m_id));
    check("ops_done",   {16'd0, ops_done},   32'(m_ops));
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    m_valid = 0; m_p = 0; m_id = 0; m_ptr = 0; m_ops = 0; last_grant = -1;
    rst = 1'b1; req_valid = 4'hF; req_x = '0; req_y = '0; resp_ready = 1'b0;

    // Reset with every requester asking
    cycle(1'b1, 4'hF, 32'h11223344, 32'h55667788, 1'b1);
    cycle(1'b1, 4'hF, 32'h11223344, 32'h55667788, 1'b1);
    check("reset_resp_p", {16'd0, resp_p}, 32'h0);

    // Single op from requester 2: 0xFF * 0xFF
    cycle(1'b0, 4'b0100, 32'h00FF0000, 32'h00FF0000, 1'b1);
    check("single_p",  {16'd0, resp_p}, 32'hFE01);
    check("single_id", {30'd0, resp_id}, 32'd2);
    cycle(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    check("single_ops", {16'd0, ops_done}, 32'd1);

    // Fairness: all valid, pointer starts at 3 so grants run 3,0,1,2,3,0,...
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 4'hF, $urandom, $urandom, 1'b1);
      check("rr_order", 32'(last_grant), 32'((3 + i) % 4));
    end
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Backpressure: requesters 0 and 1 valid, consumer stalled for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0011, 32'h0000_0907, 32'h0000_0503, 1'b0);
    end
    check("bp_held_p", {16'd0, resp_p}, 32'd21);
    cycle(1'b0, 4'b0011, 32'h0000_0907, 32'h0000_0503, 1'b1);
    check("bp_release_grant", 32'(last_grant), 32'd1);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Corner operands through requester 2 (pointer now at 2)
    cycle(1'b0, 4'b0100, 32'h0000_0000, 32'h00AB_0000, 1'b1);
    check("corner_zero", {16'd0, resp_p}, 32'h0000);
    cycle(1'b0, 4'b0100, 32'h0001_0000, 32'h0080_0000, 1'b1);
    check("corner_one", {16'd0, resp_p}, 32'h0080);
    cycle(1'b0, 4'b0100, 32'h000F_0000, 32'h0011_0000, 1'b1);
    check("corner_0f11", {16'd0, resp_p}, 32'h00FF);

    // Reset while the buffer is full and stalled
    cycle(1'b0, 4'b1000, 32'h0500_0000, 32'h0600_0000, 1'b0);
    cycle(1'b0, 4'b1000, 32'h0500_0000, 32'h0600_0000, 1'b0);
    cycle(1'b1, 4'b1000, 32'h0500_0000, 32'h0600_0000, 1'b0);
    check("rst_full_valid", {31'd0, resp_valid}, 32'd0);
    cycle(1'b0, 4'hF, $urandom, $urandom, 1'b1);
    check("rst_full_grant", 32'(last_grant), 32'd0);

    // Randomized traffic with stalls and rare resets
    for (int i = 0; i < 60; i++) begin
      cycle(($urandom_range(0, 29) == 0), 4'($urandom), $urandom, $urandom,
            ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
